// File: rtl/ldm_stm_sequencer.sv
// LDM/STM micro-op sequencer: expands one block-transfer instruction into per-register memory ops.
// Optional: define LDM_PC_FLUSH_EN to add the pc_flush output for loads that include R15.
module ldm_stm_sequencer #(
  parameter int AW         = 32,
  parameter int XFER_BYTES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   reglist,
  input  logic [AW-1:0] base,
  input  logic          p,
  input  logic          u,
  input  logic          l,
  input  logic          w,
  input  logic          stall,
  output logic          busy,
  output logic          uop_valid,
  output logic [3:0]    uop_reg,
  output logic [AW-1:0] uop_addr,
  output logic          uop_load,
  output logic          done,
  output logic          wb_valid,
  output logic [AW-1:0] wb_value
`ifdef LDM_PC_FLUSH_EN
  ,
  output logic          pc_flush
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state, state_nx;
  logic [15:0]   remain, remain_nx, left;
  logic          wb_en, wb_en_nx;
  logic          busy_nx, uop_valid_nx, uop_load_nx, done_nx, wb_valid_nx;
  logic [3:0]    uop_reg_nx;
  logic [AW-1:0] uop_addr_nx, wb_value_nx;
  logic [4:0]    n_start;
  logic [AW-1:0] span, first_addr;

  function automatic logic [4:0] ones16(input logic [15:0] v);
    ones16 = '0;
    for (int i = 0; i < 16; i++) ones16 = ones16 + 5'(v[i]);
  endfunction

  // Scanning from the top leaves the lowest set bit as the final winner.
  function automatic logic [3:0] lowest16(input logic [15:0] v);
    lowest16 = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) lowest16 = 4'(i);
  endfunction

  always_comb begin
    n_start = ones16(reglist);
    span    = AW'(XFER_BYTES) * AW'(n_start);
    left    = remain & ~(16'b1 << uop_reg);
    case ({p, u})
      2'b01:   first_addr = base;
      2'b11:   first_addr = base + AW'(XFER_BYTES);
      2'b00:   first_addr = base - span + AW'(XFER_BYTES);
      default: first_addr = base - span;
    endcase

    state_nx     = state;
    remain_nx    = remain;
    wb_en_nx     = wb_en;
    busy_nx      = busy;
    uop_valid_nx = uop_valid;
    uop_reg_nx   = uop_reg;
    uop_addr_nx  = uop_addr;
    uop_load_nx  = uop_load;
    wb_value_nx  = wb_value;
    done_nx      = 1'b0;
    wb_valid_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          remain_nx   = reglist;
          uop_reg_nx  = lowest16(reglist);
          uop_addr_nx = first_addr;
          uop_load_nx = l;
          wb_value_nx = u ? base + span : base - span;
          wb_en_nx    = w && (n_start != 5'd0);
          busy_nx     = 1'b1;
          if (n_start != 5'd0) begin
            state_nx     = XFER;
            uop_valid_nx = 1'b1;
          end else begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end
      end
      XFER: begin
        if (!stall) begin
          remain_nx   = left;
          uop_addr_nx = uop_addr + AW'(XFER_BYTES);
          if (left == 16'd0) begin
            state_nx     = DONE;
            uop_valid_nx = 1'b0;
            done_nx      = 1'b1;
            wb_valid_nx  = wb_en;
          end else begin
            uop_reg_nx = lowest16(left);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx     = IDLE;
        busy_nx      = 1'b0;
        uop_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remain    <= '0;
      wb_en     <= 1'b0;
      busy      <= 1'b0;
      uop_valid <= 1'b0;
      uop_reg   <= '0;
      uop_addr  <= '0;
      uop_load  <= 1'b0;
      done      <= 1'b0;
      wb_valid  <= 1'b0;
      wb_value  <= '0;
    end else begin
      state     <= state_nx;
      remain    <= remain_nx;
      wb_en     <= wb_en_nx;
      busy      <= busy_nx;
      uop_valid <= uop_valid_nx;
      uop_reg   <= uop_reg_nx;
      uop_addr  <= uop_addr_nx;
      uop_load  <= uop_load_nx;
      done      <= done_nx;
      wb_valid  <= wb_valid_nx;
      wb_value  <= wb_value_nx;
    end
  end

`ifdef LDM_PC_FLUSH_EN
  logic flush_en;

  // Only an XFER->DONE completion can carry R15; the empty-list path never flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_en <= 1'b0;
      pc_flush <= 1'b0;
    end else begin
      if (state == IDLE && start) flush_en <= l && reglist[15];
      pc_flush <= done_nx && (state == XFER) && flush_en;
    end
  end
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized and directed bench for ldm_stm_sequencer against an address-list reference model.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, p, u, l, w, stall;
  logic [15:0] reglist;
  logic [31:0] base;
  logic        busy, uop_valid, uop_load, done, wb_valid;
  logic [3:0]  uop_reg;
  logic [31:0] uop_addr, wb_value;
`ifdef LDM_PC_FLUSH_EN
  logic        pc_flush;
`endif

  int checks = 0;
  int errors = 0;

  ldm_stm_sequencer #(.AW(32), .XFER_BYTES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .reglist(reglist), .base(base),
    .p(p), .u(u), .l(l), .w(w), .stall(stall),
    .busy(busy), .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_addr(uop_addr),
    .uop_load(uop_load), .done(done), .wb_valid(wb_valid), .wb_value(wb_value)
`ifdef LDM_PC_FLUSH_EN
    , .pc_flush(pc_flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    reglist = 16'($urandom);
    base    = $urandom;
    p = 1'($urandom); u = 1'($urandom); l = 1'($urandom); w = 1'($urandom);
  endtask

  // mode 0: no stall, 1: random stall, 2: first micro-op stalled 3 cycles
  task automatic run_txn(input logic [15:0] rl, input logic [31:0] b, input logic pp,
                         input logic uu, input logic ll, input logic ww, input int mode);
    int n, k, nstall, held;
    logic [31:0] a, exp_wb;
    int exp_reg[$];
    logic [31:0] exp_addr[$];
    n = $countones(rl);
    if (uu) a = pp ? b + 32'd4 : b;
    else    a = pp ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
    for (int i = 0; i < 16; i++)
      if (rl[i]) begin
        exp_reg.push_back(i);
        exp_addr.push_back(a);
        a = a + 32'd4;
      end
    exp_wb = uu ? b + 32'(4 * n) : b - 32'(4 * n);

    check_val("idle_busy", 64'(busy), 64'd0);
    start = 1'b1; reglist = rl; base = b; p = pp; u = uu; l = ll; w = ww;
    stall = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    k = 0; nstall = 0; held = 0;
    while (k < n) begin
      check_val("uop_valid", 64'(uop_valid), 64'd1);
      check_val("uop_reg", 64'(uop_reg), 64'(exp_reg[k]));
      check_val("uop_addr", 64'(uop_addr), 64'(exp_addr[k]));
      check_val("uop_load", 64'(uop_load), 64'(ll));
      check_val("busy_xfer", 64'(busy), 64'd1);
      check_val("done_early", 64'(done), 64'd0);
      if (mode == 0)      stall = 1'b0;
      else if (mode == 2) stall = (k == 0) && (held < 3);
      else                stall = ($urandom_range(0, 2) == 0) && (nstall < 40);
      start = ($urandom_range(0, 3) == 0);
      scramble_inputs();
      if (stall) begin
        nstall++;
        if (k == 0) held++;
      end else begin
        k++;
      end
      @(negedge clk);
    end
    stall = 1'b0;
    start = 1'b0;
    check_val("done", 64'(done), 64'd1);
    check_val("uop_valid_done", 64'(uop_valid), 64'd0);
    check_val("busy_done", 64'(busy), 64'd1);
    check_val("wb_valid", 64'(wb_valid), 64'(ww && (n > 0)));
    check_val("wb_value", 64'(wb_value), 64'(exp_wb));
`ifdef LDM_PC_FLUSH_EN
    check_val("pc_flush", 64'(pc_flush), 64'(ll && rl[15]));
`endif
    @(negedge clk);
    check_val("done_pulse", 64'(done), 64'd0);
    check_val("busy_idle", 64'(busy), 64'd0);
    check_val("wb_valid_pulse", 64'(wb_valid), 64'd0);
  endtask

  task automatic reset_mid();
    run_txn_start(16'h0F10, 32'h0000_4000);
    check_val("rst_uop0", 64'(uop_reg), 64'd4);
    @(negedge clk);
    check_val("rst_uop1", 64'(uop_reg), 64'd8);
    check_val("rst_addr1", 64'(uop_addr), 64'h4004);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_valid", 64'(uop_valid), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_wb", 64'(wb_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("rst_no_done", 64'(done), 64'd0);
    end
  endtask

  task automatic run_txn_start(input logic [15:0] rl, input logic [31:0] b);
    start = 1'b1; reglist = rl; base = b; p = 1'b0; u = 1'b1; l = 1'b1; w = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stall = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    check_val("rst_busy0", 64'(busy), 64'd0);
    check_val("rst_valid0", 64'(uop_valid), 64'd0);
    check_val("rst_reg0", 64'(uop_reg), 64'd0);
    check_val("rst_addr0", 64'(uop_addr), 64'd0);
    check_val("rst_done0", 64'(done), 64'd0);
    check_val("rst_wbv0", 64'(wb_valid), 64'd0);
    check_val("rst_wbval0", 64'(wb_value), 64'd0);
`ifdef LDM_PC_FLUSH_EN
    check_val("rst_flush0", 64'(pc_flush), 64'd0);
`endif
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    run_txn(16'h000B, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    run_txn(16'h8010, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_txn(16'h0006, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b1, 2);
    run_txn(16'h0000, 32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    run_txn(16'hFFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_txn(16'h8001, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    reset_mid();
    run_txn(16'h0F10, 32'h0000_4000, 1'b0, 1'b1, 1'b1, 1'b1, 0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] rl;
      rl = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_txn(rl, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
